dmem_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port `DataMemory` between `NUM_REQ` streaming-multiprocessor cores in the multi-SM build of the system. It sits between the cores' data-memory ports and the one `DataMemory` instance, and serialises one access at a time. For each granted access it drives the memory address, write data and write enable. It returns a per-requester completion pulse, plus read data for loads.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ core requests onto one single-port
// data memory with a registered read port; returns one-hot ready/response pulses.
`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 32
`endif

module dmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `DATAMEM_ADDR_WIDTH,
  parameter int DATA_W  = `DATA_WORD_LENGTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_wr_en,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                wr_q, wr_d;

  logic [ID_W-1:0]     grant_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic [NUM_REQ-1:0]  rspv_d;
  logic                wr_en_d;

  logic                any_req;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     idx;
  logic [NUM_REQ-1:0]  winner_onehot;
  logic [NUM_REQ-1:0]  grant_onehot;

  // Search ptr+1, ptr+2, ... wrapping; the last candidate is ptr itself.
  // Power-of-two NUM_REQ lets the ID_W-bit add do the modulo.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ptr_q + ID_W'(off);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign winner_onehot = NUM_REQ'(1) << winner;
  assign grant_onehot  = NUM_REQ'(1) << grant_id;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    grant_d = grant_id;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = rsp_rdata;
    ready_d = '0;
    rspv_d  = '0;
    wr_en_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(winner)*DATA_W +: DATA_W];
          wr_d    = req_wr[winner];
          ptr_d   = winner;
          grant_d = winner;
          // Ready and write enable are registered so they are clean for the ACCESS cycle.
          ready_d = winner_onehot;
          wr_en_d = req_wr[winner];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          rspv_d  = grant_onehot;
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        rdata_d = mem_rdata;
        rspv_d  = grant_onehot;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears mem_wr_en asynchronously, so a store caught mid-ACCESS never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      wr_q      <= 1'b0;
      grant_id  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      mem_wr_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      grant_id  <= grant_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rsp_rdata <= rdata_d;
      req_ready <= ready_d;
      rsp_valid <= rspv_d;
      mem_wr_en <= wr_en_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model behind it.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_wr;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic [1:0]                  grant_id;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_wr_en;
  logic [DATA_W-1:0]           mem_rdata;

  logic [DATA_W-1:0]           mem [0:255];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int viol      = 0;
  bit watch1    = 1'b0;
  bit core1_granted = 1'b0;

  dmem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .grant_id  (grant_id),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: write commits at the edge, read data registered one cycle.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Protocol watch: one-hot ready/response, write enable only alongside ready.
  always @(negedge clk) begin
    if (reset) begin
      if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) viol++;
      if (mem_wr_en && req_ready == '0) viol++;
    end
    if (watch1 && req_ready[1]) core1_granted = 1'b1;
  end

  task automatic set_req(input int core, input logic wr, input logic [7:0] addr,
                         input logic [31:0] data);
    req_wr[core] = wr;
    req_addr[core*ADDR_W +: ADDR_W] = addr;
    req_wdata[core*DATA_W +: DATA_W] = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 32'h0);
    req_valid = '1;
    repeat (3) @(negedge clk);
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else pass_cnt++; total_cnt++;
    if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); else pass_cnt++; total_cnt++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else pass_cnt++; total_cnt++;
    if (mem_addr !== 8'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem_bus: got addr %h data %h expected 0", mem_addr, mem_wdata); else pass_cnt++; total_cnt++;
    if (mem_wr_en !== 1'b0) $display("FAIL reset_mem_wr_en: got %b expected 0", mem_wr_en); else pass_cnt++; total_cnt++;
    reset = 1'b1;
    @(negedge clk);
    if (req_ready !== 4'b0001) $display("FAIL first_grant_ready: got %b expected 0001", req_ready); else pass_cnt++; total_cnt++;
    if (grant_id !== 2'd0) $display("FAIL first_grant_id: got %0d expected 0", grant_id); else pass_cnt++; total_cnt++;
    if (mem_addr !== 8'h40) $display("FAIL first_grant_addr: got %h expected 40", mem_addr); else pass_cnt++; total_cnt++;
    req_valid = '0;
    repeat (2) @(negedge clk);
    if (rsp_valid !== 4'b0001) $display("FAIL first_load_rsp_valid: got %b expected 0001", rsp_valid); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'hA000_0040) $display("FAIL first_load_rdata: got %h expected a0000040", rsp_rdata); else pass_cnt++; total_cnt++;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    set_req(2, 1'b1, 8'h05, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    @(negedge clk);
    if (req_ready !== 4'b0100) $display("FAIL store_ready: got %b expected 0100", req_ready); else pass_cnt++; total_cnt++;
    if (mem_wr_en !== 1'b1) $display("FAIL store_wr_en: got %b expected 1", mem_wr_en); else pass_cnt++; total_cnt++;
    if (mem_addr !== 8'h05 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL store_bus: got addr %h data %h expected 05 deadbeef", mem_addr, mem_wdata); else pass_cnt++; total_cnt++;
    if (grant_id !== 2'd2) $display("FAIL store_grant_id: got %0d expected 2", grant_id); else pass_cnt++; total_cnt++;
    req_valid = '0;
    @(negedge clk);
    if (rsp_valid !== 4'b0100) $display("FAIL store_rsp_valid: got %b expected 0100", rsp_valid); else pass_cnt++; total_cnt++;
    if (mem_wr_en !== 1'b0) $display("FAIL store_wr_en_drop: got %b expected 0", mem_wr_en); else pass_cnt++; total_cnt++;
    set_req(2, 1'b0, 8'h05, 32'h0);
    req_valid = 4'b0100;
    @(negedge clk);
    if (req_ready !== 4'b0100) $display("FAIL load_ready: got %b expected 0100", req_ready); else pass_cnt++; total_cnt++;
    if (mem_wr_en !== 1'b0) $display("FAIL load_wr_en: got %b expected 0", mem_wr_en); else pass_cnt++; total_cnt++;
    req_valid = '0;
    @(negedge clk);
    if (rsp_valid !== 4'b0000) $display("FAIL load_rsp_early: got %b expected 0000", rsp_valid); else pass_cnt++; total_cnt++;
    @(negedge clk);
    if (rsp_valid !== 4'b0100) $display("FAIL load_rsp_valid: got %b expected 0100", rsp_valid); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h expected deadbeef", rsp_rdata); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'h20 + 8'(i), 32'h0);
    req_valid = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_oh = 4'b0001 << k;
      @(negedge clk);
      if (req_ready !== exp_oh) $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, exp_oh); else pass_cnt++; total_cnt++;
      if (grant_id !== 2'(k)) $display("FAIL rr_grant_id_%0d: got %0d expected %0d", k, grant_id, k); else pass_cnt++; total_cnt++;
      if (mem_addr !== 8'h20 + 8'(k)) $display("FAIL rr_addr_%0d: got %h expected %h", k, mem_addr, 8'h20 + 8'(k)); else pass_cnt++; total_cnt++;
      req_valid[k] = 1'b0;
      repeat (2) @(negedge clk);
      if (rsp_valid !== exp_oh) $display("FAIL rr_rsp_valid_%0d: got %b expected %b", k, rsp_valid, exp_oh); else pass_cnt++; total_cnt++;
      if (rsp_rdata !== 32'hA000_0020 + 32'(k)) $display("FAIL rr_rdata_%0d: got %h expected %h", k, rsp_rdata, 32'hA000_0020 + 32'(k)); else pass_cnt++; total_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_oh;
    int c;
    set_req(0, 1'b1, 8'h30, 32'hB000_0000);
    set_req(3, 1'b1, 8'h33, 32'hB000_0001);
    req_valid = 4'b1001;
    for (int g = 0; g < 4; g++) begin
      c = (g % 2 == 0) ? 0 : 3;
      exp_oh = 4'b0001 << c;
      @(negedge clk);
      if (req_ready !== exp_oh) $display("FAIL b2b_ready_%0d: got %b expected %b", g, req_ready, exp_oh); else pass_cnt++; total_cnt++;
      if (mem_wr_en !== 1'b1) $display("FAIL b2b_wr_en_%0d: got %b expected 1", g, mem_wr_en); else pass_cnt++; total_cnt++;
      if (mem_wdata !== 32'hB000_0000 + 32'(g)) $display("FAIL b2b_wdata_%0d: got %h expected %h", g, mem_wdata, 32'hB000_0000 + 32'(g)); else pass_cnt++; total_cnt++;
      req_wdata[c*DATA_W +: DATA_W] = 32'hB000_0000 + 32'(g + 2);
      @(negedge clk);
      if (rsp_valid !== exp_oh) $display("FAIL b2b_rsp_valid_%0d: got %b expected %b", g, rsp_valid, exp_oh); else pass_cnt++; total_cnt++;
      if (mem_wr_en !== 1'b0) $display("FAIL b2b_wr_en_low_%0d: got %b expected 0", g, mem_wr_en); else pass_cnt++; total_cnt++;
      if (g == 3) req_valid = '0;
    end
    if (mem[8'h30] !== 32'hB000_0002) $display("FAIL b2b_mem30: got %h expected b0000002", mem[8'h30]); else pass_cnt++; total_cnt++;
    if (mem[8'h33] !== 32'hB000_0003) $display("FAIL b2b_mem33: got %h expected b0000003", mem[8'h33]); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_reset_during_access();
    set_req(1, 1'b1, 8'h10, 32'hCAFE_F00D);
    req_valid = 4'b0010;
    @(negedge clk);
    if (req_ready !== 4'b0010 || mem_wr_en !== 1'b1) $display("FAIL abort_access: got ready %b wr_en %b expected 0010 1", req_ready, mem_wr_en); else pass_cnt++; total_cnt++;
    reset = 1'b0;
    req_valid = '0;
    #1;
    if (mem_wr_en !== 1'b0) $display("FAIL abort_wr_en_drop: got %b expected 0", mem_wr_en); else pass_cnt++; total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL abort_ready_drop: got %b expected 0000", req_ready); else pass_cnt++; total_cnt++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) $display("FAIL abort_no_rsp_%0d: got %b expected 0000", i, rsp_valid); else pass_cnt++; total_cnt++;
    end
    if (mem[8'h10] !== 32'h1111_1111) $display("FAIL abort_mem10: got %h expected 11111111", mem[8'h10]); else pass_cnt++; total_cnt++;
    set_req(1, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b0010;
    @(negedge clk);
    if (req_ready !== 4'b0010) $display("FAIL abort_idle_grant: got %b expected 0010", req_ready); else pass_cnt++; total_cnt++;
    req_valid = '0;
    repeat (2) @(negedge clk);
    if (rsp_valid !== 4'b0010) $display("FAIL abort_readback_valid: got %b expected 0010", rsp_valid); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'h1111_1111) $display("FAIL abort_readback_rdata: got %h expected 11111111", rsp_rdata); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_withdraw();
    set_req(0, 1'b0, 8'h21, 32'h0);
    set_req(1, 1'b0, 8'h22, 32'h0);
    req_valid = 4'b0001;
    watch1 = 1'b1;
    @(negedge clk);
    if (req_ready !== 4'b0001) $display("FAIL withdraw_core0_ready: got %b expected 0001", req_ready); else pass_cnt++; total_cnt++;
    req_valid = 4'b0010;
    @(negedge clk);
    if (req_ready !== 4'b0000) $display("FAIL withdraw_busy_ready: got %b expected 0000", req_ready); else pass_cnt++; total_cnt++;
    req_valid = 4'b0000;
    @(negedge clk);
    if (rsp_valid !== 4'b0001) $display("FAIL withdraw_rsp_valid: got %b expected 0001", rsp_valid); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'hA000_0021) $display("FAIL withdraw_rdata: got %h expected a0000021", rsp_rdata); else pass_cnt++; total_cnt++;
    repeat (3) @(negedge clk);
    watch1 = 1'b0;
    if (core1_granted !== 1'b0) $display("FAIL withdraw_core1_granted: got %b expected 0", core1_granted); else pass_cnt++; total_cnt++;
    if (rsp_rdata !== 32'hA000_0021) $display("FAIL rdata_hold: got %h expected a0000021", rsp_rdata); else pass_cnt++; total_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] <= (i == 16) ? 32'h1111_1111 : 32'hA000_0000 + 32'(i);
    reset     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_store_load();
    test_round_robin();
    test_back_to_back();
    test_reset_during_access();
    test_withdraw();
    if (viol !== 0) $display("FAIL protocol_watch: got %0d violations expected 0", viol); else pass_cnt++; total_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
